// File: rtl/usb_rx_crc16_check_if.sv
// Byte-stream handshake between the de-stuffer, the RX CRC16 checker and the packet decoder.
interface usb_rx_crc16_check_if;
    logic        rx_sop;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_eop;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        done;
    logic        crc_ok;
    logic        crc_err;
    logic        short_err;
    logic        len_err;
    logic [10:0] byte_count;

    modport master (
        output rx_sop, rx_valid, rx_data, rx_eop,
        input  out_valid, out_data, done, crc_ok, crc_err, short_err, len_err, byte_count
    );

    modport slave (
        input  rx_sop, rx_valid, rx_data, rx_eop,
        output out_valid, out_data, done, crc_ok, crc_err, short_err, len_err, byte_count
    );
endinterface

// File: rtl/usb_rx_crc16_check.sv
// USB DATA packet CRC16 checker: strips the trailing CRC field via a two-byte hold
// pipeline, accumulates CRC16 over the forwarded payload and reports the result at EOP.
module usb_rx_crc16_check #(
    parameter int unsigned MAX_LEN = 1023
) (
    input logic                 clk,
    input logic                 reset,
    usb_rx_crc16_check_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK
    } state_t;

    localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

    state_t      state_q;
    logic [7:0]  h0_q;
    logic [7:0]  h1_q;
    logic [1:0]  fill_q;
    logic [15:0] crc_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        done_q;
    logic        crc_ok_q;
    logic        crc_err_q;
    logic        short_err_q;
    logic        len_err_q;
    logic [10:0] count_q;

    // Reflected form of x^16+x^15+x^2+1, data consumed LSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            h0_q        <= '0;
            h1_q        <= '0;
            fill_q      <= '0;
            crc_q       <= '1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            short_err_q <= 1'b0;
            len_err_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            // SOP restarts from any state; an accompanying byte is the new packet's first.
            if (bus.rx_sop) begin
                state_q     <= bus.rx_eop ? S_CHECK : S_RECV;
                h0_q        <= bus.rx_valid ? bus.rx_data : 8'h00;
                h1_q        <= '0;
                fill_q      <= bus.rx_valid ? 2'd1 : 2'd0;
                crc_q       <= '1;
                crc_ok_q    <= 1'b0;
                crc_err_q   <= 1'b0;
                short_err_q <= 1'b0;
                len_err_q   <= 1'b0;
                count_q     <= '0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_RECV: begin
                        if (bus.rx_valid) begin
                            if (fill_q == 2'd2) begin
                                crc_q <= crc16_upd(crc_q, h0_q);
                                h0_q  <= h1_q;
                                h1_q  <= bus.rx_data;
                                // Past MAX_LEN the CRC still runs but forwarding stops.
                                if (count_q < MAX_CNT) begin
                                    out_valid_q <= 1'b1;
                                    out_data_q  <= h0_q;
                                    count_q     <= count_q + 11'd1;
                                end else begin
                                    len_err_q <= 1'b1;
                                end
                            end else if (fill_q == 2'd1) begin
                                h1_q   <= bus.rx_data;
                                fill_q <= 2'd2;
                            end else begin
                                h0_q   <= bus.rx_data;
                                fill_q <= 2'd1;
                            end
                        end
                        if (bus.rx_eop) state_q <= S_CHECK;
                    end
                    S_CHECK: begin
                        done_q <= 1'b1;
                        if (fill_q != 2'd2) begin
                            short_err_q <= 1'b1;
                            crc_err_q   <= 1'b1;
                        end else if ({h1_q, h0_q} == ~crc_q) begin
                            crc_ok_q <= 1'b1;
                        end else begin
                            crc_err_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.done       = done_q;
    assign bus.crc_ok     = crc_ok_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.short_err  = short_err_q;
    assign bus.len_err    = len_err_q;
    assign bus.byte_count = count_q;

endmodule

// File: tb/tb_usb_rx_crc16_check.sv
// Self-checking bench for usb_rx_crc16_check: two instances (MAX_LEN 1023 and 4) share stimulus.
module tb_usb_rx_crc16_check;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb_rx_crc16_check_if bu ();
    usb_rx_crc16_check_if bs ();

    usb_rx_crc16_check u_big (.clk(clk), .reset(reset), .bus(bu.slave));
    usb_rx_crc16_check #(.MAX_LEN(4)) u_small (.clk(clk), .reset(reset), .bus(bs.slave));

    typedef struct packed {
        logic [7:0]  dones;
        logic        ok;
        logic        err;
        logic        sh;
        logic        le;
        logic [10:0] cnt;
        logic [10:0] nout;
    } res_t;

    res_t       ru, rs;
    logic [7:0] gu[$], gs[$];
    int         tests = 0;
    int         fails = 0;

    always @(negedge clk) begin
        if (bu.out_valid) begin gu.push_back(bu.out_data); ru.nout = ru.nout + 11'd1; end
        if (bs.out_valid) begin gs.push_back(bs.out_data); rs.nout = rs.nout + 11'd1; end
        if (bu.done) begin
            ru.dones = ru.dones + 8'd1;
            ru.ok = bu.crc_ok; ru.err = bu.crc_err; ru.sh = bu.short_err; ru.le = bu.len_err;
            ru.cnt = bu.byte_count;
        end
        if (bs.done) begin
            rs.dones = rs.dones + 8'd1;
            rs.ok = bs.crc_ok; rs.err = bs.crc_err; rs.sh = bs.short_err; rs.le = bs.len_err;
            rs.cnt = bs.byte_count;
        end
    end

    // Reference CRC: the transmitted bit stream (LSB first) divided by 0x8005 in plain
    // MSB-first polynomial form, then bit-reversed and complemented into the CRC field.
    function automatic logic [15:0] model_crc(input logic [7:0] p[$]);
        bit          bits[$];
        logic [15:0] r, rev;
        bit          fb;
        foreach (p[k]) for (int i = 0; i < 8; i++) bits.push_back(p[k][i]);
        r = 16'hFFFF;
        foreach (bits[j]) begin
            fb = r[15] ^ bits[j];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        for (int i = 0; i < 16; i++) rev[i] = r[15-i];
        return ~rev;
    endfunction

    function automatic void with_crc(input logic [7:0] p[$], output logic [7:0] b[$]);
        logic [15:0] f;
        f = model_crc(p);
        b = p;
        b.push_back(f[7:0]);
        b.push_back(f[15:8]);
    endfunction

    function automatic void split(input logic [7:0] b[$], output logic [7:0] p[$]);
        p.delete();
        for (int i = 0; i + 2 < b.size(); i++) p.push_back(b[i]);
    endfunction

    function automatic res_t exp_res(input logic [7:0] b[$], input int maxl);
        res_t        r;
        logic [7:0]  p[$];
        int          pl;
        r = '0;
        r.dones = 8'd1;
        if (b.size() < 2) begin
            r.err = 1'b1;
            r.sh  = 1'b1;
        end else begin
            split(b, p);
            pl     = p.size();
            r.ok   = ({b[b.size()-1], b[b.size()-2]} == model_crc(p));
            r.err  = !r.ok;
            r.le   = pl > maxl;
            r.cnt  = 11'((pl > maxl) ? maxl : pl);
            r.nout = r.cnt;
        end
        return r;
    endfunction

    function automatic void exp_data(input logic [7:0] b[$], input int maxl, inout logic [7:0] q[$]);
        logic [7:0] p[$];
        split(b, p);
        foreach (p[i]) if (i < maxl) q.push_back(p[i]);
    endfunction

    function automatic logic [31:0] sig(input logic [7:0] q[$]);
        logic [31:0] s;
        s = 32'(q.size());
        foreach (q[i]) s = (s * 32'd33) ^ 32'(q[i]);
        return s;
    endfunction

    task automatic step(input logic sop, input logic v, input logic [7:0] d, input logic eop);
        bu.rx_sop = sop; bu.rx_valid = v; bu.rx_data = d; bu.rx_eop = eop;
        bs.rx_sop = sop; bs.rx_valid = v; bs.rx_data = d; bs.rx_eop = eop;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ru = '0; rs = '0;
        gu.delete(); gs.delete();
    endtask

    // Tail cycles carry junk rx_valid/rx_eop, which CHECK and IDLE must ignore.
    task automatic send_pkt(input logic [7:0] b[$], input bit sop_sep, input bit eop_sep,
                            input bit gaps, input int tail);
        int n;
        n = b.size();
        if (sop_sep || n == 0) step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 8'($urandom), 1'b0);
            step(i == 0 && !sop_sep, 1'b1, b[i], (i == n - 1) && !eop_sep);
        end
        if (n == 0 || eop_sep) step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < tail; i++) step(1'b0, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        tests++;
        if ({bu.out_valid, bu.out_data, bu.done, bu.crc_ok, bu.crc_err, bu.short_err, bu.len_err,
             bu.byte_count, bs.out_valid, bs.out_data, bs.done, bs.crc_ok, bs.crc_err,
             bs.short_err, bs.len_err, bs.byte_count} !== '0) begin
            fails++;
            $display("FAIL reset_values got out_valid=%b out_data=%h done=%b flags=%b%b%b%b count=%0d, required all zero",
                     bu.out_valid, bu.out_data, bu.done, bu.crc_ok, bu.crc_err, bu.short_err,
                     bu.len_err, bu.byte_count);
        end
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_zero_len();
        logic [7:0] b[$];
        logic [7:0] ed[$];
        b = '{8'h00, 8'h00};
        clear_mon();
        send_pkt(b, 1'b0, 1'b1, 1'b0, 3);
        tests++;
        if (ru !== exp_res(b, 1023)) begin
            fails++; $display("FAIL zero_len got=%h required=%h", ru, exp_res(b, 1023));
        end
        tests++;
        if (ru.ok !== 1'b1 || ru.nout !== 11'd0) begin
            fails++; $display("FAIL zero_len_ok got ok=%b nout=%0d required ok=1 nout=0", ru.ok, ru.nout);
        end
        exp_data(b, 1023, ed);
        tests++;
        if (sig(gu) !== sig(ed)) begin
            fails++; $display("FAIL zero_len_data got=%h required=%h", sig(gu), sig(ed));
        end
    endtask

    task automatic test_corrupt();
        logic [7:0] b[$];
        b = '{8'h00, 8'h01};
        clear_mon();
        send_pkt(b, 1'b1, 1'b0, 1'b0, 3);
        tests++;
        if (ru !== exp_res(b, 1023) || ru.err !== 1'b1 || ru.ok !== 1'b0 || ru.sh !== 1'b0) begin
            fails++; $display("FAIL corrupt got=%h required=%h", ru, exp_res(b, 1023));
        end
    endtask

    task automatic test_payload();
        logic [7:0] p[$], b[$], ed[$];
        p = '{8'h01, 8'h02, 8'h03};
        with_crc(p, b);
        clear_mon();
        send_pkt(b, 1'b0, 1'b0, 1'b0, 3);
        ed = '{8'h01, 8'h02, 8'h03};
        tests++;
        if (sig(gu) !== sig(ed)) begin
            fails++; $display("FAIL payload_data got_sig=%h required_sig=%h n=%0d", sig(gu), sig(ed), gu.size());
        end
        tests++;
        if (ru.ok !== 1'b1 || ru.cnt !== 11'd3 || ru !== exp_res(b, 1023)) begin
            fails++; $display("FAIL payload_result got=%h required=%h", ru, exp_res(b, 1023));
        end
        b[1] = 8'h06;
        clear_mon();
        send_pkt(b, 1'b0, 1'b0, 1'b0, 3);
        tests++;
        if (ru.err !== 1'b1 || ru.ok !== 1'b0 || ru !== exp_res(b, 1023)) begin
            fails++; $display("FAIL payload_corrupt got=%h required=%h", ru, exp_res(b, 1023));
        end
    endtask

    task automatic test_short();
        logic [7:0] p[$], b[$];
        b = '{8'hAA};
        clear_mon();
        send_pkt(b, 1'b0, 1'b1, 1'b0, 3);
        tests++;
        if (ru.sh !== 1'b1 || ru.err !== 1'b1 || ru.cnt !== 11'd0 || ru !== exp_res(b, 1023)) begin
            fails++; $display("FAIL short got=%h required=%h", ru, exp_res(b, 1023));
        end
        p = '{8'h5A, 8'hC3};
        with_crc(p, b);
        clear_mon();
        send_pkt(b, 1'b0, 1'b0, 1'b0, 3);
        tests++;
        if (ru.ok !== 1'b1 || ru !== exp_res(b, 1023)) begin
            fails++; $display("FAIL eop_with_last got=%h required=%h", ru, exp_res(b, 1023));
        end
    endtask

    task automatic test_abort();
        logic [7:0] b[$];
        clear_mon();
        for (int i = 0; i < 5; i++) step(i == 0, 1'b1, 8'($urandom), 1'b0);
        @(negedge clk);
        #1;
        gu.delete(); gs.delete(); ru.nout = '0; rs.nout = '0;
        b = '{8'h00, 8'h00};
        send_pkt(b, 1'b0, 1'b0, 1'b0, 3);
        tests++;
        if (ru.dones !== 8'd1 || ru.ok !== 1'b1 || ru !== exp_res(b, 1023)) begin
            fails++; $display("FAIL abort got=%h required=%h", ru, exp_res(b, 1023));
        end
    endtask

    task automatic test_oversize();
        logic [7:0] p[$], b[$], eu[$], es[$];
        repeat (6) p.push_back(8'($urandom));
        with_crc(p, b);
        clear_mon();
        send_pkt(b, 1'b1, 1'b1, 1'b0, 3);
        exp_data(b, 1023, eu);
        exp_data(b, 4, es);
        tests++;
        if (rs.nout !== 11'd4 || rs.le !== 1'b1 || rs.ok !== 1'b1 || rs.cnt !== 11'd4 || rs !== exp_res(b, 4)) begin
            fails++; $display("FAIL oversize_small got=%h required=%h", rs, exp_res(b, 4));
        end
        tests++;
        if (sig(gs) !== sig(es)) begin
            fails++; $display("FAIL oversize_small_data got=%h required=%h", sig(gs), sig(es));
        end
        tests++;
        if (ru !== exp_res(b, 1023) || sig(gu) !== sig(eu)) begin
            fails++; $display("FAIL oversize_big got=%h required=%h", ru, exp_res(b, 1023));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        clear_mon();
        for (int i = 0; i < 3; i++) step(i == 0, 1'b1, 8'($urandom), 1'b0);
        step(1'b0, 1'b1, 8'($urandom), 1'b0);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bu.out_valid, bu.out_data, bu.done, bu.crc_ok, bu.crc_err, bu.short_err, bu.len_err,
             bu.byte_count} !== '0) begin
            fails++;
            $display("FAIL reset_mid got out_valid=%b out_data=%h count=%0d, required all zero",
                     bu.out_valid, bu.out_data, bu.byte_count);
        end
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        b = '{8'h00, 8'h00};
        clear_mon();
        send_pkt(b, 1'b0, 1'b0, 1'b0, 3);
        tests++;
        if (ru.ok !== 1'b1 || ru !== exp_res(b, 1023)) begin
            fails++; $display("FAIL reset_mid_recover got=%h required=%h", ru, exp_res(b, 1023));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p[$], b[$], eu[$], es[$];
        res_t       e_u, e_s;
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            p.delete();
            repeat ($urandom_range(0, 7)) p.push_back(8'($urandom));
            with_crc(p, b);
            if (k == 1) b[0] = b[0] ^ 8'h80;
            exp_data(b, 1023, eu);
            exp_data(b, 4, es);
            e_u.nout = (k == 0) ? 11'd0 : e_u.nout;
            e_s.nout = (k == 0) ? 11'd0 : e_s.nout;
            e_u = '{dones: 8'(k + 1), ok: exp_res(b, 1023).ok, err: exp_res(b, 1023).err,
                    sh: exp_res(b, 1023).sh, le: exp_res(b, 1023).le, cnt: exp_res(b, 1023).cnt,
                    nout: e_u.nout + exp_res(b, 1023).nout};
            e_s = '{dones: 8'(k + 1), ok: exp_res(b, 4).ok, err: exp_res(b, 4).err,
                    sh: exp_res(b, 4).sh, le: exp_res(b, 4).le, cnt: exp_res(b, 4).cnt,
                    nout: e_s.nout + exp_res(b, 4).nout};
            send_pkt(b, 1'b0, 1'b0, 1'b0, (k == 2) ? 3 : 1);
        end
        tests++;
        if (ru !== e_u || sig(gu) !== sig(eu)) begin
            fails++; $display("FAIL back_to_back_big got=%h required=%h", ru, e_u);
        end
        tests++;
        if (rs !== e_s || sig(gs) !== sig(es)) begin
            fails++; $display("FAIL back_to_back_small got=%h required=%h", rs, e_s);
        end
    endtask

    task automatic test_random();
        logic [7:0] p[$], b[$], eu[$], es[$];
        int         n;
        for (int t = 0; t < 30; t++) begin
            p.delete();
            repeat ($urandom_range(0, 10)) p.push_back(8'($urandom));
            with_crc(p, b);
            case ($urandom_range(0, 5))
                0: begin
                    n = $urandom_range(0, b.size() - 1);
                    b[n] = b[n] ^ 8'(1 << $urandom_range(0, 7));
                end
                1: begin
                    n = $urandom_range(0, 1);
                    while (b.size() > n) b.pop_back();
                end
                default: ;
            endcase
            eu.delete(); es.delete();
            exp_data(b, 1023, eu);
            exp_data(b, 4, es);
            clear_mon();
            send_pkt(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 3);
            tests++;
            if (ru !== exp_res(b, 1023) || sig(gu) !== sig(eu)) begin
                fails++; $display("FAIL random_big[%0d] len=%0d got=%h required=%h", t, b.size(), ru, exp_res(b, 1023));
            end
            tests++;
            if (rs !== exp_res(b, 4) || sig(gs) !== sig(es)) begin
                fails++; $display("FAIL random_small[%0d] len=%0d got=%h required=%h", t, b.size(), rs, exp_res(b, 4));
            end
        end
    endtask

    initial begin
        bu.rx_sop = 1'b0; bu.rx_valid = 1'b0; bu.rx_data = '0; bu.rx_eop = 1'b0;
        bs.rx_sop = 1'b0; bs.rx_valid = 1'b0; bs.rx_data = '0; bs.rx_eop = 1'b0;
        ru = '0; rs = '0;
        test_reset();
        test_zero_len();
        test_corrupt();
        test_payload();
        test_short();
        test_abort();
        test_oversize();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

endmodule
